// File: rtl/mem_stage_split_if.sv
// EX/MEM/WB bus for the split-handshake MEM stage: EX-side fields, SRAM response,
// WB handshake and the forwarding/stall info returned to ID.
interface mem_stage_split_if #(
  parameter int DATA_W = 32,
  parameter int SIDE_W = 86
);
  localparam int AW = $clog2(DATA_W/8);

  logic              ex_mem_valid;
  logic              mem_allowin;
  logic              ex_mem_req;
  logic              ex_mem_load;
  logic [2:0]        ex_mem_type;
  logic [AW-1:0]     ex_mem_addr_low;
  logic [DATA_W-1:0] ex_mem_result;
  logic              ex_mem_gr_we;
  logic [4:0]        ex_mem_dest;
  logic              ex_mem_ex;
  logic [SIDE_W-1:0] ex_mem_side;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              flush;
  logic              mem_wb_valid;
  logic              wb_allowin;
  logic [DATA_W-1:0] mem_wb_result;
  logic              mem_wb_gr_we;
  logic [4:0]        mem_wb_dest;
  logic [SIDE_W-1:0] mem_wb_side;
  logic              mem_ex;
  logic              mem_fwd_valid;
  logic [4:0]        mem_fwd_dest;
  logic [DATA_W-1:0] mem_fwd_data;
  logic              mem_fwd_stall;

  modport master (
    output ex_mem_valid, ex_mem_req, ex_mem_load, ex_mem_type, ex_mem_addr_low,
           ex_mem_result, ex_mem_gr_we, ex_mem_dest, ex_mem_ex, ex_mem_side,
           data_sram_data_ok, data_sram_rdata, flush, wb_allowin,
    input  mem_allowin, mem_wb_valid, mem_wb_result, mem_wb_gr_we, mem_wb_dest,
           mem_wb_side, mem_ex, mem_fwd_valid, mem_fwd_dest, mem_fwd_data, mem_fwd_stall
  );

  modport slave (
    input  ex_mem_valid, ex_mem_req, ex_mem_load, ex_mem_type, ex_mem_addr_low,
           ex_mem_result, ex_mem_gr_we, ex_mem_dest, ex_mem_ex, ex_mem_side,
           data_sram_data_ok, data_sram_rdata, flush, wb_allowin,
    output mem_allowin, mem_wb_valid, mem_wb_result, mem_wb_gr_we, mem_wb_dest,
           mem_wb_side, mem_ex, mem_fwd_valid, mem_fwd_dest, mem_fwd_data, mem_fwd_stall
  );
endinterface

// File: rtl/mem_stage_split.sv
// MEM stage for a split-handshake data SRAM: waits for data_ok, buffers rdata across
// WB stalls, aligns/extends load data and discards responses of flushed instructions.
module mem_stage_split #(
  parameter int DATA_W     = 32,
  parameter int SIDE_W     = 86,
  parameter int MAX_CANCEL = 3
) (
  input  logic             clk,
  input  logic             resetn,
  mem_stage_split_if.slave bus
);
  localparam int AW = $clog2(DATA_W/8);
  localparam int CW = $clog2(MAX_CANCEL+1);
  localparam int IW = $clog2(DATA_W);

  typedef struct packed {
    logic              load;
    logic [2:0]        mtype;
    logic [AW-1:0]     addr_low;
    logic [DATA_W-1:0] result;
    logic              gr_we;
    logic [4:0]        dest;
    logic              ex;
    logic [SIDE_W-1:0] side;
  } mem_fields_t;

  mem_fields_t       f;
  logic              mem_valid, waiting, rbuf_valid;
  logic [DATA_W-1:0] rbuf;
  logic [CW-1:0]     cancel_cnt, cancel_nxt;
  logic              resp_hit, ready_go, accept, cnt_dec, cnt_inc;
  logic [DATA_W-1:0] ld_src, shifted, ld_data, res;
  logic [IW-1:0]     msb;
  logic              fill;

  // A response only belongs to us once every stale response has been drained.
  assign resp_hit = waiting & bus.data_sram_data_ok & (cancel_cnt == '0);
  assign ready_go = ~waiting | resp_hit;
  assign accept   = bus.ex_mem_valid & bus.mem_allowin & ~bus.flush;

  assign bus.mem_allowin  = ~mem_valid | (ready_go & bus.wb_allowin);
  assign bus.mem_wb_valid = mem_valid & ready_go & ~bus.flush;

  assign cnt_dec = bus.data_sram_data_ok & (cancel_cnt != '0);
  assign cnt_inc = bus.flush & waiting & ~resp_hit;

  always_comb begin
    cancel_nxt = cancel_cnt;
    if (cnt_dec & ~cnt_inc)
      cancel_nxt = cancel_cnt - CW'(1);
    else if (cnt_inc & ~cnt_dec & (cancel_cnt != CW'(MAX_CANCEL)))
      cancel_nxt = cancel_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid  <= 1'b0;
      waiting    <= 1'b0;
      rbuf_valid <= 1'b0;
      cancel_cnt <= '0;
    end else begin
      cancel_cnt <= cancel_nxt;
      if (bus.flush) begin
        mem_valid  <= 1'b0;
        waiting    <= 1'b0;
        rbuf_valid <= 1'b0;
      end else if (bus.mem_allowin) begin
        mem_valid  <= bus.ex_mem_valid;
        waiting    <= bus.ex_mem_valid & bus.ex_mem_req;
        rbuf_valid <= 1'b0;
      end else if (resp_hit) begin
        // WB stalled on the response cycle: hold the data locally.
        waiting    <= 1'b0;
        rbuf_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      f <= '{load: bus.ex_mem_load, mtype: bus.ex_mem_type, addr_low: bus.ex_mem_addr_low,
             result: bus.ex_mem_result, gr_we: bus.ex_mem_gr_we, dest: bus.ex_mem_dest,
             ex: bus.ex_mem_ex, side: bus.ex_mem_side};
    if (resp_hit & ~bus.mem_allowin & ~bus.flush)
      rbuf <= bus.data_sram_rdata;
  end

  // Size D only exists on a 64-bit datapath; otherwise it behaves as W.
  always_comb begin
    ld_src  = rbuf_valid ? rbuf : bus.data_sram_rdata;
    shifted = ld_src >> {f.addr_low, 3'b000};
    case (f.mtype[1:0])
      2'b01:   msb = IW'(15);
      2'b10:   msb = IW'(7);
      2'b11:   msb = (DATA_W == 64) ? IW'(63) : IW'(31);
      default: msb = IW'(31);
    endcase
    fill    = ~f.mtype[2] & shifted[msb];
    ld_data = shifted;
    for (int i = 0; i < DATA_W; i++)
      if (i > int'(msb)) ld_data[i] = fill;
  end

  assign res = f.load ? ld_data : f.result;

  assign bus.mem_wb_result = mem_valid ? res : '0;
  assign bus.mem_wb_gr_we  = mem_valid & f.gr_we;
  assign bus.mem_wb_dest   = mem_valid ? f.dest : 5'd0;
  assign bus.mem_wb_side   = mem_valid ? f.side : '0;
  assign bus.mem_ex        = mem_valid & f.ex;
  assign bus.mem_fwd_valid = mem_valid & f.gr_we & (f.dest != 5'd0);
  assign bus.mem_fwd_dest  = bus.mem_wb_dest;
  assign bus.mem_fwd_data  = bus.mem_wb_result;
  assign bus.mem_fwd_stall = mem_valid & f.load & waiting;
endmodule

// File: tb/tb_mem_stage_split.sv
// Drives a 32-bit and a 64-bit mem_stage_split with identical stimulus and checks both
// against a transaction-level model of the stage occupant and the stale-response count.
module tb_mem_stage_split;
  localparam int SW = 86;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_split_if #(.DATA_W(32), .SIDE_W(SW)) b32 ();
  mem_stage_split_if #(.DATA_W(64), .SIDE_W(SW)) b64 ();

  mem_stage_split #(.DATA_W(32), .SIDE_W(SW), .MAX_CANCEL(3)) dut32 (
    .clk(clk), .resetn(resetn), .bus(b32.slave));
  mem_stage_split #(.DATA_W(64), .SIDE_W(SW), .MAX_CANCEL(3)) dut64 (
    .clk(clk), .resetn(resetn), .bus(b64.slave));

  logic          ex_valid, req, load, we, exb, data_ok, flush, wb_allowin;
  logic [2:0]    typ, addr;
  logic [63:0]   alu, rdata;
  logic [4:0]    dest;
  logic [SW-1:0] side;

  assign b32.ex_mem_valid = ex_valid;       assign b64.ex_mem_valid = ex_valid;
  assign b32.ex_mem_req = req;              assign b64.ex_mem_req = req;
  assign b32.ex_mem_load = load;            assign b64.ex_mem_load = load;
  assign b32.ex_mem_type = typ;             assign b64.ex_mem_type = typ;
  assign b32.ex_mem_addr_low = addr[1:0];   assign b64.ex_mem_addr_low = addr;
  assign b32.ex_mem_result = alu[31:0];     assign b64.ex_mem_result = alu;
  assign b32.ex_mem_gr_we = we;             assign b64.ex_mem_gr_we = we;
  assign b32.ex_mem_dest = dest;            assign b64.ex_mem_dest = dest;
  assign b32.ex_mem_ex = exb;               assign b64.ex_mem_ex = exb;
  assign b32.ex_mem_side = side;            assign b64.ex_mem_side = side;
  assign b32.data_sram_data_ok = data_ok;   assign b64.data_sram_data_ok = data_ok;
  assign b32.data_sram_rdata = rdata[31:0]; assign b64.data_sram_rdata = rdata;
  assign b32.flush = flush;                 assign b64.flush = flush;
  assign b32.wb_allowin = wb_allowin;       assign b64.wb_allowin = wb_allowin;

  // Model: who occupies MEM, whether it still owes a response, and how many
  // responses in flight belong to flushed instructions.
  logic          m_occ, m_pend, m_load, m_we, m_ex;
  logic [2:0]    m_typ, m_addr;
  logic [63:0]   m_alu, m_buf;
  logic [4:0]    m_dest;
  logic [SW-1:0] m_side;
  int            m_stale;
  logic          e_hit, e_done, e_allow;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ld_ext(input int dw, input logic [2:0] t,
                                         input logic [2:0] a, input logic [63:0] d);
    logic [63:0] sh;
    logic [1:0]  sz;
    sz = t[1:0];
    if (dw == 32) begin
      sh = {32'd0, d[31:0] >> (8 * a[1:0])};
      if (sz == 2'd3) sz = 2'd0;
    end else begin
      sh = d >> (8 * a);
    end
    case (sz)
      2'd2:    return t[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    return t[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd0:    return t[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  task automatic eval();
    logic [63:0] r64, r32;
    logic        fv;
    #2;
    e_hit   = m_occ && m_pend && data_ok && (m_stale == 0);
    e_done  = m_occ && (!m_pend || e_hit);
    e_allow = !m_occ || (e_done && wb_allowin);
    r64 = m_load ? ld_ext(64, m_typ, m_addr, e_hit ? rdata : m_buf) : m_alu;
    r32 = m_load ? ld_ext(32, m_typ, m_addr, e_hit ? rdata : m_buf) : m_alu;
    fv  = m_occ && m_we && (m_dest != 5'd0);
    chk("allowin32", b32.mem_allowin, e_allow);
    chk("allowin64", b64.mem_allowin, e_allow);
    chk("wb_valid32", b32.mem_wb_valid, e_done && !flush);
    chk("wb_valid64", b64.mem_wb_valid, e_done && !flush);
    chk("fwd_valid32", b32.mem_fwd_valid, fv);
    chk("fwd_valid64", b64.mem_fwd_valid, fv);
    chk("fwd_stall32", b32.mem_fwd_stall, m_occ && m_load && m_pend);
    chk("fwd_stall64", b64.mem_fwd_stall, m_occ && m_load && m_pend);
    chk("mem_ex32", b32.mem_ex, m_occ && m_ex);
    chk("mem_ex64", b64.mem_ex, m_occ && m_ex);
    if (e_done) begin
      chk("result32", b32.mem_wb_result, r32[31:0]);
      chk("result64", b64.mem_wb_result, r64);
      chk("fwd_data32", b32.mem_fwd_data, r32[31:0]);
      chk("gr_we32", b32.mem_wb_gr_we, m_we);
      chk("dest64", b64.mem_wb_dest, m_dest);
      chk("side32", b32.mem_wb_side, m_side);
    end
    if (fv) chk("fwd_dest64", b64.mem_fwd_dest, m_dest);
  endtask

  task automatic tick();
    @(posedge clk);
    if (data_ok && m_stale > 0) m_stale--;
    if (flush && m_occ && m_pend && !e_hit && m_stale < 3) m_stale++;
    if (flush) begin
      m_occ = 1'b0;
    end else if (e_allow) begin
      m_occ = ex_valid; m_pend = req; m_load = load; m_typ = typ; m_addr = addr;
      m_alu = alu; m_we = we; m_dest = dest; m_ex = exb; m_side = side;
    end else if (e_hit) begin
      m_pend = 1'b0;
      m_buf  = rdata;
    end
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; req = 0; load = 0; typ = 0; addr = 0; alu = 0; we = 0; dest = 0;
    exb = 0; side = '0; data_ok = 0; rdata = 0; flush = 0; wb_allowin = 1;
  endtask

  task automatic issue_load(input logic [2:0] t, input logic [2:0] a, input logic [4:0] d);
    ex_valid = 1; req = 1; load = 1; typ = t; addr = a; we = 1; dest = d;
    alu = {$urandom, $urandom}; side = SW'({$urandom, $urandom, $urandom});
  endtask

  initial begin
    idle();
    m_occ = 0; m_pend = 0; m_stale = 0; m_buf = 0;
    #12;
    chk("rst_wb_valid", b32.mem_wb_valid, 1'b0);
    chk("rst_fwd_valid", b64.mem_fwd_valid, 1'b0);
    chk("rst_fwd_stall", b32.mem_fwd_stall, 1'b0);
    chk("rst_mem_ex", b64.mem_ex, 1'b0);
    chk("rst_result", b32.mem_wb_result, 32'd0);
    chk("rst_allowin", b32.mem_allowin, 1'b1);
    @(posedge clk); #1;
    resetn = 1'b1;

    // ld.b at byte 3, response on the first MEM cycle
    idle(); issue_load(3'b010, 3'd3, 5'd5); eval(); tick();
    idle(); data_ok = 1; rdata = 64'h0000_0000_80AB_CDEF; eval();
    chk("t1_valid", b32.mem_wb_valid, 1'b1);
    chk("t1_res", b32.mem_wb_result, 32'hFFFF_FF80);
    tick();

    // ld.hu at byte 2, response three cycles late
    idle(); issue_load(3'b101, 3'd2, 5'd6); eval(); tick();
    repeat (3) begin
      idle(); eval(); chk("t2_stall", b32.mem_fwd_stall, 1'b1); tick();
    end
    idle(); data_ok = 1; rdata = 64'h0000_0000_8000_1234; eval();
    chk("t2_res", b32.mem_wb_result, 32'h0000_8000);
    tick();

    // response arrives while WB stalls; rdata changes afterwards
    idle(); issue_load(3'b000, 3'd0, 5'd7); eval(); tick();
    idle(); wb_allowin = 0; data_ok = 1; rdata = 64'h1111_2222_3333_4444; eval(); tick();
    repeat (2) begin
      idle(); wb_allowin = 0; rdata = 64'hDEAD_BEEF_DEAD_BEEF; eval();
      chk("t3_allowin", b32.mem_allowin, 1'b0); tick();
    end
    idle(); rdata = 64'h5555_6666_7777_8888; eval();
    chk("t3_res", b32.mem_wb_result, 32'h3333_4444);
    tick();

    // flush while waiting; the old response must not complete the next load
    idle(); issue_load(3'b000, 3'd0, 5'd8); eval(); tick();
    idle(); flush = 1; eval(); tick();
    idle(); issue_load(3'b010, 3'd1, 5'd9); eval(); tick();
    idle(); data_ok = 1; rdata = 64'h0000_0000_7777_7777; eval();
    chk("t4_drop", b32.mem_wb_valid, 1'b0);
    chk("t4_stall", b32.mem_fwd_stall, 1'b1);
    tick();
    idle(); data_ok = 1; rdata = 64'h0000_0000_0000_AB00; eval();
    chk("t4_valid", b32.mem_wb_valid, 1'b1);
    chk("t4_res", b32.mem_wb_result, 32'hFFFF_FFAB);
    tick();

    // doubleword then word at byte 4 on the 64-bit datapath
    idle(); issue_load(3'b011, 3'd0, 5'd10); eval(); tick();
    idle(); data_ok = 1; rdata = 64'h8765_4321_0000_0001; eval();
    chk("t5_ld_d", b64.mem_wb_result, 64'h8765_4321_0000_0001);
    tick();
    idle(); issue_load(3'b000, 3'd4, 5'd11); eval(); tick();
    idle(); data_ok = 1; rdata = 64'h8765_4321_0000_0001; eval();
    chk("t5_ld_w", b64.mem_wb_result, 64'hFFFF_FFFF_8765_4321);
    tick();

    // asynchronous reset while a load waits
    idle(); issue_load(3'b000, 3'd0, 5'd12); exb = 1; eval(); tick();
    idle(); eval();
    chk("t6_pre_ex", b32.mem_ex, 1'b1);
    resetn = 1'b0;
    #1;
    chk("t6_wb_valid", b32.mem_wb_valid, 1'b0);
    chk("t6_fwd_valid", b32.mem_fwd_valid, 1'b0);
    chk("t6_fwd_stall", b32.mem_fwd_stall, 1'b0);
    chk("t6_fwd_dest", b32.mem_fwd_dest, 5'd0);
    chk("t6_mem_ex", b32.mem_ex, 1'b0);
    chk("t6_mem_ex64", b64.mem_ex, 1'b0);
    chk("t6_fwd_stall64", b64.mem_fwd_stall, 1'b0);
    m_occ = 0; m_pend = 0; m_stale = 0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      ex_valid   = $urandom_range(0, 3) != 0;
      load       = 1'($urandom_range(0, 1));
      req        = load | 1'($urandom_range(0, 1));
      typ        = 3'($urandom);
      addr       = 3'($urandom);
      alu        = {$urandom, $urandom};
      we         = 1'($urandom_range(0, 1));
      dest       = 5'($urandom_range(0, 31));
      exb        = $urandom_range(0, 7) == 0;
      side       = SW'({$urandom, $urandom, $urandom});
      data_ok    = $urandom_range(0, 2) == 0;
      rdata      = {$urandom, $urandom};
      flush      = $urandom_range(0, 15) == 0;
      wb_allowin = $urandom_range(0, 3) != 0;
      eval();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
